// File: rtl/snn_sim_scheduler.sv
// Timestep sequencer for the SNN core: clears the network, then per timestep
// loads every input-spike batch and fires each layer in turn, waiting for done.
module snn_sim_scheduler #(
  parameter int NUM_LAYERS                     = 2,
  parameter int MAX_TIMESTEPS_BITS             = 8,
  parameter int SPIKE_PATTERN_BATCH_ADDR_WIDTH = 1
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       start,
  input  logic                                                       abort,
  input  logic [MAX_TIMESTEPS_BITS:0]                                sim_time,
  output logic                                                       busy,
  output logic                                                       done,
  output logic                                                       net_clear,
  output logic                                                       pat_rd_en,
  output logic [MAX_TIMESTEPS_BITS+SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] pat_rd_addr,
  output logic                                                       batch_load,
  output logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0]                  batch_sel,
  output logic [NUM_LAYERS-1:0]                                      layer_start,
  input  logic [NUM_LAYERS-1:0]                                      layer_done,
  output logic [MAX_TIMESTEPS_BITS:0]                                timestep
);

  localparam int TW = MAX_TIMESTEPS_BITS + 1;
  localparam int BW = SPIKE_PATTERN_BATCH_ADDR_WIDTH;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [BW-1:0] LAST_BATCH = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_LSTART, S_LWAIT, S_NEXT, S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_st_lat;
  logic [TW-1:0]  r_ts;
  logic [BW-1:0]  r_batch;
  logic [LW-1:0]  r_layer;
  logic [TW-1:0]  w_ts_inc;
  logic           w_layer_hit;

  assign w_ts_inc    = r_ts + TW'(1);
  assign w_layer_hit = layer_done[r_layer];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // abort outranks every transition once a run has left IDLE
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_CLEAR;
        S_CLEAR:  w_next = (r_st_lat == '0) ? S_DONE : S_FETCH;
        S_FETCH:  w_next = S_LOAD;
        S_LOAD:   w_next = (r_batch == LAST_BATCH) ? S_LSTART : S_FETCH;
        S_LSTART: w_next = S_LWAIT;
        S_LWAIT:  if (w_layer_hit) w_next = (r_layer == LAST_LAYER) ? S_NEXT : S_LSTART;
        S_NEXT:   w_next = (w_ts_inc == r_st_lat) ? S_DONE : S_FETCH;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Counters freeze on abort and are reloaded by the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_lat <= '0;
      r_ts     <= '0;
      r_batch  <= '0;
      r_layer  <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_st_lat <= sim_time;
        r_ts     <= '0;
        r_batch  <= '0;
        r_layer  <= '0;
      end
    end else if (!abort) begin
      case (r_state)
        S_LOAD:  r_batch <= (r_batch == LAST_BATCH) ? '0 : r_batch + BW'(1);
        S_LWAIT: if (w_layer_hit) r_layer <= (r_layer == LAST_LAYER) ? '0 : r_layer + LW'(1);
        S_NEXT:  r_ts <= w_ts_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    net_clear   = 1'b0;
    pat_rd_en   = 1'b0;
    batch_load  = 1'b0;
    layer_start = '0;
    case (r_state)
      S_CLEAR:  begin busy = 1'b1; net_clear = 1'b1; end
      S_FETCH:  begin busy = 1'b1; pat_rd_en = 1'b1; end
      S_LOAD:   begin busy = 1'b1; batch_load = 1'b1; end
      S_LSTART: begin busy = 1'b1; layer_start = NUM_LAYERS'(1) << r_layer; end
      S_LWAIT:  busy = 1'b1;
      S_NEXT:   busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Only the low timestep bits address memory; the extra MSB is for termination
  assign pat_rd_addr = {r_ts[MAX_TIMESTEPS_BITS-1:0], r_batch};
  assign batch_sel   = r_batch;
  assign timestep    = r_ts;

endmodule
